// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel position from HS/VS, checks
// sync timing against the configured mode and streams active-area pixels once locked.
module vga_sync_decoder #(
   parameter int unsigned H_BITS      = 11,
   parameter int unsigned V_BITS      = 11,
   parameter int unsigned HD          = 1280,
   parameter int unsigned HF          = 48,
   parameter int unsigned HR          = 112,
   parameter int unsigned HB          = 248,
   parameter int unsigned VD          = 1024,
   parameter int unsigned VF          = 1,
   parameter int unsigned VR          = 3,
   parameter int unsigned VB          = 38,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic              clk,
   input  logic              arstn,
   input  logic              vga_hs_i,
   input  logic              vga_vs_i,
   input  logic [11:0]       rgb_i,
   output logic              pix_valid_o,
   output logic [H_BITS-1:0] pix_x_o,
   output logic [V_BITS-1:0] pix_y_o,
   output logic [11:0]       pix_rgb_o,
   output logic              frame_start_o,
   output logic              locked_o,
   output logic              hsync_err_o,
   output logic              vsync_err_o,
   output logic [7:0]        err_cnt_o
);
   localparam int unsigned HTOTAL = HD + HF + HR + HB;
   localparam int unsigned VTOTAL = VD + VF + VR + VB;
   localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(HTOTAL - 1);
   localparam logic [H_BITS-1:0] H_PW     = H_BITS'(HR - 1);
   localparam logic [H_BITS-1:0] H_ACT_LO = H_BITS'(HR + HB);
   localparam logic [H_BITS-1:0] H_ACT_HI = H_BITS'(HR + HB + HD);
   localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(VTOTAL - 1);
   localparam logic [V_BITS-1:0] V_PW     = V_BITS'(VR - 1);
   localparam logic [V_BITS-1:0] V_ACT_LO = V_BITS'(VR + VB);
   localparam logic [V_BITS-1:0] V_ACT_HI = V_BITS'(VR + VB + VD);
   localparam logic [3:0]        GOOD_LOCK = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   state_t            state, state_nxt;
   logic [3:0]        good, good_nxt, good_inc;
   logic              hs_q, hs_qq, vs_q, vs_qq;
   logic [11:0]       rgb_q;
   logic [H_BITS-1:0] hcnt, hcnt_nxt;
   logic [V_BITS-1:0] vcnt, vcnt_nxt;
   logic              h_seen;
   logic              hs_rise, hs_fall, vs_rise, vs_fall;
   logic              armed, h_err, v_err, active, emit;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         hs_q  <= 1'b0;
         hs_qq <= 1'b0;
         vs_q  <= 1'b0;
         vs_qq <= 1'b0;
         rgb_q <= '0;
      end else begin
         hs_q  <= vga_hs_i;
         hs_qq <= hs_q;
         vs_q  <= vga_vs_i;
         vs_qq <= vs_q;
         rgb_q <= rgb_i;
      end
   end

   assign hs_rise = hs_q & ~hs_qq;
   assign hs_fall = ~hs_q & hs_qq;
   assign vs_rise = vs_q & ~vs_qq;
   assign vs_fall = ~vs_q & vs_qq;

   // rgb_q sits at position hcnt_nxt/vcnt_nxt: the HS rise cycle itself is position 0
   always_comb begin
      hcnt_nxt = (hcnt == '1) ? hcnt : hcnt + H_BITS'(1);
      if (hs_rise) hcnt_nxt = '0;
      vcnt_nxt = vcnt;
      if (hs_rise) begin
         if (vs_rise)           vcnt_nxt = '0;
         else if (vcnt != '1)   vcnt_nxt = vcnt + V_BITS'(1);
      end
   end

   assign armed  = (state != SEARCH);
   assign h_err  = armed & ((hs_rise & h_seen & (hcnt != H_LAST)) |
                            (hs_fall & (hcnt != H_PW)));
   assign v_err  = armed & ((vs_rise & ((vcnt != V_LAST) | ~hs_rise)) |
                            (vs_fall & (vcnt != V_PW)));
   assign active = (hcnt_nxt >= H_ACT_LO) && (hcnt_nxt < H_ACT_HI) &&
                   (vcnt_nxt >= V_ACT_LO) && (vcnt_nxt < V_ACT_HI);
   assign emit   = (state == LOCKED) & active;
   assign good_inc = good + 4'd1;

   always_comb begin
      state_nxt = state;
      good_nxt  = good;
      case (state)
         SEARCH: begin
            if (vs_rise) begin
               state_nxt = ACQUIRE;
               good_nxt  = '0;
            end
         end
         ACQUIRE: begin
            if (h_err | v_err) begin
               state_nxt = SEARCH;
            end else if (vs_rise) begin
               good_nxt = good_inc;
               if (good_inc == GOOD_LOCK) state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (h_err | v_err) state_nxt = SEARCH;
         end
         default: state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state  <= SEARCH;
         good   <= '0;
         hcnt   <= '0;
         vcnt   <= '0;
         h_seen <= 1'b0;
      end else begin
         state <= state_nxt;
         good  <= good_nxt;
         hcnt  <= hcnt_nxt;
         vcnt  <= vcnt_nxt;
         if (armed && state_nxt == SEARCH) h_seen <= 1'b0;
         else if (hs_rise)                 h_seen <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         hsync_err_o   <= 1'b0;
         vsync_err_o   <= 1'b0;
         err_cnt_o     <= '0;
         locked_o      <= 1'b0;
         pix_valid_o   <= 1'b0;
         frame_start_o <= 1'b0;
         pix_x_o       <= '0;
         pix_y_o       <= '0;
         pix_rgb_o     <= '0;
      end else begin
         hsync_err_o   <= h_err;
         vsync_err_o   <= v_err;
         if ((hsync_err_o | vsync_err_o) && err_cnt_o != '1)
            err_cnt_o <= err_cnt_o + 8'd1;
         locked_o      <= (state == LOCKED);
         pix_valid_o   <= emit;
         frame_start_o <= emit & (hcnt_nxt == H_ACT_LO) & (vcnt_nxt == V_ACT_LO);
         if (emit) begin
            pix_x_o   <= hcnt_nxt - H_ACT_LO;
            pix_y_o   <= vcnt_nxt - V_ACT_LO;
            pix_rgb_o <= rgb_q;
         end
      end
   end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder in a small video mode: generator model drives
// frames with injected faults, a scoreboard checks the pixel stream and error behaviour.
module tb_vga_sync_decoder;
   localparam int HD = 8, HF = 2, HR = 2, HB = 3;
   localparam int VD = 4, VF = 1, VR = 2, VB = 1;
   localparam int HTOT = HD + HF + HR + HB;
   localparam int VTOT = VD + VF + VR + VB;
   localparam int F_NONE = 0, F_SHORT = 1, F_WIDE = 2, F_NOVS = 3, F_RST = 4;

   typedef struct {
      logic [10:0] x;
      logic [10:0] y;
      logic [11:0] rgb;
      int          stamp;
   } px_t;

   typedef struct {
      int fault;
      int px_upto;
      int recover;
      int herr;
      int verr;
      int fs;
      int cnt;
   } scen_t;

   logic        clk = 1'b0, arstn = 1'b0, hs = 1'b0, vs = 1'b0;
   logic [11:0] rgb = '0;
   logic        pix_valid_o, frame_start_o, locked_o, hsync_err_o, vsync_err_o;
   logic [10:0] pix_x_o, pix_y_o;
   logic [11:0] pix_rgb_o;
   logic [7:0]  err_cnt_o;

   px_t sb[$];
   int  total = 0, bad = 0, cyc = 0;
   int  h_pulses = 0, v_pulses = 0, fs_cnt = 0;

   vga_sync_decoder #(
      .H_BITS(11), .V_BITS(11),
      .HD(HD), .HF(HF), .HR(HR), .HB(HB),
      .VD(VD), .VF(VF), .VR(VR), .VB(VB),
      .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .arstn(arstn), .vga_hs_i(hs), .vga_vs_i(vs), .rgb_i(rgb),
      .pix_valid_o(pix_valid_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
      .pix_rgb_o(pix_rgb_o), .frame_start_o(frame_start_o), .locked_o(locked_o),
      .hsync_err_o(hsync_err_o), .vsync_err_o(vsync_err_o), .err_cnt_o(err_cnt_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      px_t e;
      if (hsync_err_o) h_pulses++;
      if (vsync_err_o) v_pulses++;
      if (frame_start_o) fs_cnt++;
      if (pix_valid_o) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pixel: got x=%0d y=%0d expected no pixel", pix_x_o, pix_y_o);
         end else begin
            e = sb.pop_front();
            chk("pixel{x,y,rgb,fs,lat}",
                {pix_x_o, pix_y_o, pix_rgb_o, frame_start_o, 8'(cyc - e.stamp)},
                {e.x, e.y, e.rgb, (e.x == 11'd0 && e.y == 11'd0), 8'd2});
         end
      end else if (frame_start_o) begin
         total++;
         bad++;
         $display("FAIL frame_start_without_valid: got 1 expected 0");
      end
   end

   // one generator line; cut pulls arstn low mid-active-line for 3 clocks
   task automatic send_line(input int len, input int hw, input int vw,
                            input bit px, input int vl, input bit cut);
      px_t e;
      for (int h = 0; h < len; h++) begin
         @(negedge clk);
         hs  = (h < hw);
         vs  = (h < vw);
         rgb = 12'($urandom_range(0, 4095));
         if (px && h >= HR + HB && h < HR + HB + HD && vl >= VR + VB && vl < VR + VB + VD
             && !(cut && h > HR + HB)) begin
            e.x = 11'(h - (HR + HB));
            e.y = 11'(vl - (VR + VB));
            e.rgb = rgb;
            e.stamp = cyc;
            sb.push_back(e);
         end
         if (cut && h == HR + HB + 2) begin
            #2 arstn = 1'b0;
            #1 chk("outputs_in_reset",
                   {pix_valid_o, locked_o, frame_start_o, hsync_err_o, vsync_err_o,
                    err_cnt_o, pix_x_o, pix_y_o, pix_rgb_o}, 64'd0);
         end
         if (cut && h == HR + HB + 5) #2 arstn = 1'b1;
      end
   endtask

   task automatic gen_frame(input int fault, input int px_upto);
      int len, hw, vw;
      for (int vl = 0; vl < VTOT; vl++) begin
         len = (fault == F_SHORT && vl == 5) ? HTOT - 1 : HTOT;
         hw  = (fault == F_WIDE && vl == 5) ? HR + 1 : HR;
         vw  = (fault != F_NOVS && vl < VR) ? len : 0;
         send_line(len, hw, vw, vl <= px_upto, vl, fault == F_RST && vl == 4);
      end
   endtask

   initial begin
      scen_t tbl[5];
      int hb, vb, fb;
      tbl[0] = '{F_NONE,  7, 0, 0, 0, 2, 0};
      tbl[1] = '{F_SHORT, 5, 2, 1, 0, 2, 1};
      tbl[2] = '{F_WIDE,  4, 2, 1, 0, 2, 2};
      tbl[3] = '{F_NOVS, -1, 3, 0, 1, 1, 3};
      tbl[4] = '{F_RST,   4, 2, 0, 0, 2, 0};

      repeat (3) @(negedge clk);
      chk("reset_state",
          {pix_valid_o, locked_o, frame_start_o, hsync_err_o, vsync_err_o,
           err_cnt_o, pix_x_o, pix_y_o, pix_rgb_o}, 64'd0);
      #2 arstn = 1'b1;

      gen_frame(F_NONE, -1);
      gen_frame(F_NONE, -1);
      chk("locked_after_2_vs", locked_o, 1'b0);
      gen_frame(F_NONE, 7);
      chk("locked_after_3_vs", locked_o, 1'b1);
      chk("acquire_errors", {h_pulses, v_pulses}, 64'd0);
      chk("acquire_frame_starts", fs_cnt, 1);

      for (int i = 0; i < 5; i++) begin
         hb = h_pulses;
         vb = v_pulses;
         fb = fs_cnt;
         gen_frame(tbl[i].fault, tbl[i].px_upto);
         for (int r = 0; r < tbl[i].recover; r++) begin
            gen_frame(F_NONE, -1);
            if (r == 0) chk($sformatf("s%0d_unlocked", i), locked_o, 1'b0);
         end
         gen_frame(F_NONE, 7);
         chk($sformatf("s%0d_hsync_pulses", i), h_pulses - hb, tbl[i].herr);
         chk($sformatf("s%0d_vsync_pulses", i), v_pulses - vb, tbl[i].verr);
         chk($sformatf("s%0d_frame_starts", i), fs_cnt - fb, tbl[i].fs);
         chk($sformatf("s%0d_err_cnt", i), err_cnt_o, tbl[i].cnt);
         chk($sformatf("s%0d_relocked", i), locked_o, 1'b1);
         chk($sformatf("s%0d_pixels_drained", i), sb.size(), 0);
      end

      // a VS pulse on every line forces one vsync error per line
      hb = h_pulses;
      vb = v_pulses;
      for (int n = 0; n < 200; n++) send_line(HTOT, HR, HR, 1'b0, 0, 1'b0);
      chk("err_cnt_200", err_cnt_o, 200);
      for (int n = 0; n < 100; n++) send_line(HTOT, HR, HR, 1'b0, 0, 1'b0);
      chk("err_cnt_saturated", err_cnt_o, 255);
      chk("sat_vsync_pulses", v_pulses - vb, 300);
      chk("sat_hsync_pulses", h_pulses - hb, 0);
      chk("sat_unlocked", locked_o, 1'b0);
      chk("final_pixels_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog expired");
   end
endmodule
